// File: rtl/rv32i_enc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rv32i_enc_pkg
// Description : Shared definitions for the RV32I instruction encoder:
//               base opcodes, op-class codes carried on op_class, and the
//               load-session FSM state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package rv32i_enc_pkg;

    // RV32I base opcodes (instr[6:0])
    localparam logic [6:0] OPC_R      = 7'b0110011;
    localparam logic [6:0] OPC_IALU   = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    // Operation classes presented on op_class; codes above 8 are illegal
    typedef enum logic [3:0] {
        CLS_R      = 4'd0,
        CLS_IALU   = 4'd1,
        CLS_LOAD   = 4'd2,
        CLS_STORE  = 4'd3,
        CLS_BRANCH = 4'd4,
        CLS_JAL    = 4'd5,
        CLS_JALR   = 4'd6,
        CLS_LUI    = 4'd7,
        CLS_AUIPC  = 4'd8
    } op_class_e;

    // Load-session FSM state
    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_LOAD = 2'd1;
    localparam state_t ST_DONE = 2'd2;

endpackage
`default_nettype wire

// File: rtl/rv32i_instr_encode.sv
`default_nettype none
// ============================================================================
// Module      : rv32i_instr_encode
// Description : Purely combinational encoder from decoded fields to a
//               32-bit RV32I machine word plus an illegal-bundle flag.
// Ports       : i_op_class/i_fun3/i_fun7/i_rd/i_rs1/i_rs2/i_imm - fields
//               o_word    - encoded instruction word
//               o_illegal - bundle cannot be encoded and must be dropped
// Revision    : 1.0 - initial release
// ============================================================================
module rv32i_instr_encode
    import rv32i_enc_pkg::*;
(
    input  logic [3:0]  i_op_class,
    input  logic [2:0]  i_fun3,
    input  logic        i_fun7,
    input  logic [4:0]  i_rd,
    input  logic [4:0]  i_rs1,
    input  logic [4:0]  i_rs2,
    input  logic [31:0] i_imm,
    output logic [31:0] o_word,
    output logic        o_illegal
);

    logic w_shift;

    always_comb begin
        w_shift   = (i_fun3 == 3'b001) || (i_fun3 == 3'b101);
        o_word    = 32'd0;
        o_illegal = 1'b0;
        case (i_op_class)
            CLS_R: begin
                o_word    = {1'b0, i_fun7, 5'b00000, i_rs2, i_rs1, i_fun3, i_rd, OPC_R};
                // Only add/sub and srl/sra have a funct7[5] variant
                o_illegal = i_fun7 && (i_fun3 != 3'b000) && (i_fun3 != 3'b101);
            end
            CLS_IALU: begin
                // Shift-immediates carry shamt in imm[4:0] and funct7 above it
                if (w_shift)
                    o_word = {1'b0, i_fun7, 5'b00000, i_imm[4:0], i_rs1, i_fun3, i_rd, OPC_IALU};
                else
                    o_word = {i_imm[11:0], i_rs1, i_fun3, i_rd, OPC_IALU};
                o_illegal = i_fun7 && (i_fun3 != 3'b101);
            end
            CLS_LOAD: begin
                o_word    = {i_imm[11:0], i_rs1, i_fun3, i_rd, OPC_LOAD};
                o_illegal = (i_fun3 == 3'b011) || (i_fun3 == 3'b110) || (i_fun3 == 3'b111);
            end
            CLS_STORE: begin
                o_word    = {i_imm[11:5], i_rs2, i_rs1, i_fun3, i_imm[4:0], OPC_STORE};
                o_illegal = (i_fun3 > 3'b010);
            end
            CLS_BRANCH: begin
                o_word    = {i_imm[12], i_imm[10:5], i_rs2, i_rs1, i_fun3,
                             i_imm[4:1], i_imm[11], OPC_BRANCH};
                o_illegal = (i_fun3 == 3'b010) || (i_fun3 == 3'b011) || i_imm[0];
            end
            CLS_JAL: begin
                o_word    = {i_imm[20], i_imm[10:1], i_imm[11], i_imm[19:12], i_rd, OPC_JAL};
                o_illegal = i_imm[0];
            end
            CLS_JALR: begin
                o_word = {i_imm[11:0], i_rs1, 3'b000, i_rd, OPC_JALR};
            end
            CLS_LUI: begin
                o_word = {i_imm[31:12], i_rd, OPC_LUI};
            end
            CLS_AUIPC: begin
                o_word = {i_imm[31:12], i_rd, OPC_AUIPC};
            end
            default: begin
                o_illegal = 1'b1;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/rv32i_instr_encoder.sv
`default_nettype none
// ============================================================================
// Module      : rv32i_instr_encoder
// Description : Accepts decoded instruction bundles over valid/ready,
//               encodes them into RV32I words, buffers them in a small FIFO
//               and writes them sequentially into instruction memory.
// Ports       : clk, rst (sync, active-low)
//               start/base_addr/num_instr - begin a load session
//               in_valid/in_ready + field bundle - instruction input
//               imem_we/imem_addr/imem_wdata/imem_ready - imem write port
//               busy/done/err/err_count - session status
// Revision    : 1.0 - initial release
// ============================================================================
module rv32i_instr_encoder
    import rv32i_enc_pkg::*;
#(
    parameter int FIFO_DEPTH = 2,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [31:0]      base_addr,
    input  logic [CNT_W-1:0] num_instr,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op_class,
    input  logic [2:0]       fun3,
    input  logic             fun7,
    input  logic [4:0]       rd,
    input  logic [4:0]       rs1,
    input  logic [4:0]       rs2,
    input  logic [31:0]      imm,
    output logic             imem_we,
    output logic [31:0]      imem_addr,
    output logic [31:0]      imem_wdata,
    input  logic             imem_ready,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [7:0]       err_count
);

    localparam int                 c_PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [c_PTR_W:0]   c_FULL  = FIFO_DEPTH[c_PTR_W:0];

    state_t             r_state,    w_state_nxt;
    logic [31:0]        r_addr,     w_addr_nxt;
    logic [CNT_W-1:0]   r_num,      w_num_nxt;
    logic [CNT_W-1:0]   r_accepted, w_accepted_nxt;
    logic [CNT_W-1:0]   r_written,  w_written_nxt;
    logic               r_err,      w_err_nxt;
    logic [7:0]         r_err_count, w_err_count_nxt;
    logic [c_PTR_W-1:0] r_wr_ptr,   w_wr_ptr_nxt;
    logic [c_PTR_W-1:0] r_rd_ptr,   w_rd_ptr_nxt;
    logic [c_PTR_W:0]   r_count,    w_count_nxt;
    logic [31:0]        r_fifo [FIFO_DEPTH];

    logic [31:0] w_word;
    logic        w_illegal;
    logic        w_full, w_empty, w_xfer, w_push, w_pop;

    rv32i_instr_encode u_encode (
        .i_op_class (op_class),
        .i_fun3     (fun3),
        .i_fun7     (fun7),
        .i_rd       (rd),
        .i_rs1      (rs1),
        .i_rs2      (rs2),
        .i_imm      (imm),
        .o_word     (w_word),
        .o_illegal  (w_illegal)
    );

    assign w_full   = (r_count == c_FULL);
    assign w_empty  = (r_count == '0);
    assign in_ready = (r_state == ST_LOAD) && !w_full && (r_accepted < r_num);
    assign w_xfer   = in_valid && in_ready;
    // Illegal bundles are consumed but never reach the FIFO
    assign w_push   = w_xfer && !w_illegal;
    assign w_pop    = imem_we && imem_ready;

    assign imem_we    = !w_empty;
    assign imem_addr  = r_addr;
    // Gate the head so a flushed FIFO presents zero rather than stale data
    assign imem_wdata = w_empty ? 32'd0 : r_fifo[r_rd_ptr];
    assign busy       = (r_state == ST_LOAD) || (r_state == ST_DONE);
    assign done       = (r_state == ST_DONE);
    assign err        = r_err;
    assign err_count  = r_err_count;

    always_comb begin
        w_state_nxt     = r_state;
        w_addr_nxt      = r_addr;
        w_num_nxt       = r_num;
        w_accepted_nxt  = r_accepted;
        w_written_nxt   = r_written;
        w_wr_ptr_nxt    = r_wr_ptr;
        w_rd_ptr_nxt    = r_rd_ptr;
        w_count_nxt     = r_count;
        w_err_nxt       = w_xfer && w_illegal;
        w_err_count_nxt = r_err_count;

        if (w_err_nxt && (r_err_count != 8'hFF))
            w_err_count_nxt = r_err_count + 8'd1;

        if (w_push) begin
            w_wr_ptr_nxt   = r_wr_ptr + 1'b1;
            w_accepted_nxt = r_accepted + 1'b1;
        end
        if (w_pop) begin
            w_rd_ptr_nxt  = r_rd_ptr + 1'b1;
            w_addr_nxt    = r_addr + 32'd4;
            w_written_nxt = r_written + 1'b1;
        end
        if (w_push && !w_pop)
            w_count_nxt = r_count + 1'b1;
        else if (!w_push && w_pop)
            w_count_nxt = r_count - 1'b1;

        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_addr_nxt     = base_addr;
                    w_num_nxt      = num_instr;
                    w_accepted_nxt = '0;
                    w_written_nxt  = '0;
                    w_state_nxt    = (num_instr == '0) ? ST_DONE : ST_LOAD;
                end
            end
            ST_LOAD: begin
                // Leave as soon as the final write is accepted, so done
                // follows the last write by exactly one cycle
                if (w_pop && (w_written_nxt == r_num))
                    w_state_nxt = ST_DONE;
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= ST_IDLE;
            r_addr      <= 32'd0;
            r_num       <= '0;
            r_accepted  <= '0;
            r_written   <= '0;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_err       <= 1'b0;
            r_err_count <= 8'd0;
        end else begin
            r_state     <= w_state_nxt;
            r_addr      <= w_addr_nxt;
            r_num       <= w_num_nxt;
            r_accepted  <= w_accepted_nxt;
            r_written   <= w_written_nxt;
            r_wr_ptr    <= w_wr_ptr_nxt;
            r_rd_ptr    <= w_rd_ptr_nxt;
            r_count     <= w_count_nxt;
            r_err       <= w_err_nxt;
            r_err_count <= w_err_count_nxt;
        end
    end

    // Storage needs no reset: occupancy is tracked by the pointers/count
    always_ff @(posedge clk) begin
        if (w_push)
            r_fifo[r_wr_ptr] <= w_word;
    end

endmodule
`default_nettype wire

// File: doc/rv32i_instr_encoder.md
Name: rv32i_instr_encoder

Overview:
Inverse of the ID-stage control decoder. Takes decoded instruction fields (op class, fun3, fun7, rd, rs1, rs2, imm) over a valid/ready handshake and encodes them into RV32I machine words. Buffers the words and writes them sequentially into instruction memory. Used as the program loader and bench stimulus source, and sits in front of the imem write port.

Parameters:
FIFO_DEPTH, 2, encoded-word buffer entries (power of 2, >=2)
CNT_W, 16, width of instruction count

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  synchronous reset, active-low
start  in  1  one-cycle pulse, begins a load session; ignored unless IDLE
base_addr  in  32  first imem byte address, sampled on start
num_instr  in  CNT_W  legal words to write this session, sampled on start
in_valid  in  1  field bundle valid
in_ready  out  1  encoder can accept bundle
op_class  in  4  0 R, 1 I-alu, 2 load, 3 store, 4 branch, 5 jal, 6 jalr, 7 lui, 8 auipc
fun3  in  3  funct3
fun7  in  1  funct7[5] (instr bit 30)
rd, rs1, rs2  in  5 each  register indices
imm  in  32  immediate, unencoded byte offset / value
imem_we  out  1  write request
imem_addr  out  32  write byte address
imem_wdata  out  32  encoded word
imem_ready  in  1  memory accepts write when imem_we&imem_ready
busy  out  1  session active
done  out  1  one-cycle pulse, session complete
err  out  1  one-cycle pulse, illegal bundle dropped
err_count  out  8  saturating count of dropped bundles

Behaviour:
- Reset (rst==0 at edge): state IDLE, FIFO flushed; in_ready, imem_we, busy, done, err = 0; imem_addr, imem_wdata, err_count = 0.
- FSM IDLE -> LOAD on start. If num_instr==0, go IDLE -> DONE instead. LOAD -> DONE when written==num_instr. DONE -> IDLE after one cycle; done=1 only in DONE. busy=1 in LOAD and DONE.
- Handshake: in_ready = LOAD & fifo not full & accepted<num_instr. A transfer occurs on in_valid&in_ready. Fields may change freely when in_ready==0.
- Encoding, combinational in the sub-module:
  - R: {0,fun7,00000,rs2,rs1,fun3,rd,0110011}
  - I-alu 0010011: shifts (fun3 001/101) use {0,fun7,00000,imm[4:0]}; otherwise imm[11:0].
  - load 0000011: I format.
  - jalr 1100111: I format, fun3 forced 000.
  - store 0100011: {imm[11:5],rs2,rs1,fun3,imm[4:0],op}
  - branch 1100011: {imm[12],imm[10:5],rs2,rs1,fun3,imm[4:1],imm[11],op}
  - jal 1101111: {imm[20],imm[10:1],imm[11],imm[19:12],rd,op}
  - lui 0110111 / auipc 0010111: {imm[31:12],rd,op}
- Illegal bundles are accepted, not pushed, and raise err for 1 cycle. They do not count toward accepted or written. err_count saturates at 255 and is not cleared by start. A bundle is illegal if any of:
  - op_class>8
  - R with fun7=1 and fun3 not 000/101
  - I-alu with fun7=1 and fun3!=101
  - load fun3 in {011,110,111}
  - store fun3>010
  - branch fun3 in {010,011}
  - branch or jal with imm[0]=1
- Latency: a word accepted at cycle N is presented as imem_we=1 at N+1 at the earliest. imem_we = fifo not empty; imem_addr/imem_wdata come from the FIFO head and current address.
- Write completes on imem_we&imem_ready: pop, imem_addr+=4 (mod 2^32 wrap), written+=1. Address and data hold stable while imem_ready==0.
- Simultaneous push and pop when full is not allowed (in_ready already low). Push and pop in the same cycle when not full keep occupancy unchanged.
- start during LOAD/DONE is ignored.
- Reset mid-session aborts: buffered words are discarded, no done pulse.

Decomposition:
- Package rv32i_enc_pkg:
  - opcode constants (OPC_R, OPC_IALU, OPC_LOAD, OPC_STORE, OPC_BRANCH, OPC_JAL, OPC_JALR, OPC_LUI, OPC_AUIPC)
  - op_class enum values 0-8
  - FSM state typedef
- Sub-module rv32i_instr_encode: purely combinational fields->{word, illegal}. The top holds the FSM, counters, FIFO and address register.

Test Plan:
- base 0x100, n=1; R fun3=0 fun7=0 rd=3 rs1=1 rs2=2 -> single write addr 0x100 data 0x002081B3, done pulse one cycle after write.
- Same fields with fun7=1 (sub) -> 0x402081B3; branch fun3=0 rs1=1 rs2=2 imm=8 -> 0x00208463; both in one session n=2 at 0x100/0x104.
- jal rd=1 imm=0x800 -> 0x001000EF; lui rd=5 imm=0x12345000 -> 0x123452B7.
- R fun3=001 fun7=1 -> no imem write, err=1 one cycle, err_count=1, session still waits for n legal words; 300 illegal -> err_count=255.
- n=3 with imem_ready held low 3 cycles -> FIFO fills at 2, in_ready=0, no loss, writes at 0x100, 0x104, 0x108 in order.
- Assert rst low mid-LOAD with 1 word buffered -> next cycle imem_we=0, busy=0, no done; num_instr=0 start -> done pulse, no writes.
